corr_feeder: RTL and testbench

Sample source for the 64-point complex lag-correlation MAC. Accepts a stream of complex samples over a valid/ready handshake, buffers them in a FIFO and keeps a LAG-deep delay line. Drives the MAC's `en`, `xn_re/xn_im` (sample n) and `xn4_re/xn4_im` (sample n+LAG) in 64-cycle frames. Slot 63 of each frame is a bubble, matching the MAC's dump cycle.

---
 rtl/corr_feeder.sv | 193 +++++++++++++++++++
 tb/tb_corr_feeder.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/corr_feeder.sv
// corr_feeder: FIFO-buffered sample source for the 64-point complex lag-correlation MAC.
// Define CORR_FEEDER_CONJ_EN to drive xn4_im as the saturated negation (conjugate lag sample).

module corr_feeder #(
   parameter int DW      = 16,
   parameter int FRAME   = 64,
   parameter int LAG     = 4,
   parameter int FIFO_AW = 7
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             s_valid,
   output logic             s_ready,
   input  logic [DW-1:0]    s_re,
   input  logic [DW-1:0]    s_im,
   output logic             en,
   output logic [DW-1:0]    xn_re,
   output logic [DW-1:0]    xn_im,
   output logic [DW-1:0]    xn4_re,
   output logic [DW-1:0]    xn4_im,
   output logic             frame_done,
   output logic [5:0]       slot,
   output logic [FIFO_AW:0] fifo_level
);

   localparam int DEPTH = 1 << FIFO_AW;
   localparam logic [FIFO_AW:0] FULL_LVL   = (FIFO_AW+1)'(DEPTH);
   localparam logic [FIFO_AW:0] PRIME_LVL  = (FIFO_AW+1)'(LAG);
   localparam logic [FIFO_AW:0] START_LVL  = (FIFO_AW+1)'(FRAME-1);
   localparam logic [5:0]       LAST_SLOT  = 6'(FRAME-1);
   localparam logic [5:0]       BUB_PREV   = 6'(FRAME-2);
   localparam logic [3:0]       PRIME_LAST = 4'(LAG-1);

   typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;

   state_t             state_q, state_d;
   logic [DW-1:0]      mem_re [DEPTH];
   logic [DW-1:0]      mem_im [DEPTH];
   logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
   logic               push, pop, start, take;
   logic [DW-1:0]      head_re, head_im, head_im_x;
   logic [DW-1:0]      dl_re [LAG];
   logic [DW-1:0]      dl_im [LAG];
   logic               primed, primed_d;
   logic [3:0]         prime_cnt, prime_cnt_d;
   logic               en_d, fd_d;
   logic [5:0]         slot_d;
   logic [DW-1:0]      xn_re_d, xn_im_d, xn4_re_d, xn4_im_d;

   assign s_ready = (fifo_level != FULL_LVL);
   assign push    = s_valid && s_ready;
   assign head_re = mem_re[rd_ptr];
   assign head_im = mem_im[rd_ptr];

`ifdef CORR_FEEDER_CONJ_EN
   localparam logic [DW-1:0] MOST_NEG = {1'b1, {(DW-1){1'b0}}};
   localparam logic [DW-1:0] MOST_POS = {1'b0, {(DW-1){1'b1}}};
   assign head_im_x = (head_im == MOST_NEG) ? MOST_POS : ~head_im + 1'b1;
`else
   assign head_im_x = head_im;
`endif

   always_ff @(posedge clk) begin
      if (push) begin
         mem_re[wr_ptr] <= s_re;
         mem_im[wr_ptr] <= s_im;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_level <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop)      fifo_level <= fifo_level + 1'b1;
         else if (pop && !push) fifo_level <= fifo_level - 1'b1;
      end
   end

   // dl[0] is the newest sample, dl[LAG-1] the oldest (sample n).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < LAG; i++) begin
            dl_re[i] <= '0;
            dl_im[i] <= '0;
         end
      end else if (pop) begin
         dl_re[0] <= head_re;
         dl_im[0] <= head_im;
         for (int unsigned i = 1; i < LAG; i++) begin
            dl_re[i] <= dl_re[i-1];
            dl_im[i] <= dl_im[i-1];
         end
      end
   end

   // Next-cycle outputs are decided here so en/x are registered on the same edge as the pop;
   // the registered slot is therefore the slot currently presented to the MAC.
   always_comb begin
      state_d     = state_q;
      primed_d    = primed;
      prime_cnt_d = prime_cnt;
      slot_d      = slot;
      pop         = 1'b0;
      start       = 1'b0;
      take        = 1'b0;
      en_d        = 1'b0;
      fd_d        = 1'b0;
      xn_re_d     = '0;
      xn_im_d     = '0;
      xn4_re_d    = '0;
      xn4_im_d    = '0;
      case (state_q)
         IDLE: begin
            if (!primed && fifo_level >= PRIME_LVL) begin
               state_d     = PRIME;
               prime_cnt_d = '0;
            end else if (primed && fifo_level >= START_LVL) begin
               start = 1'b1;
            end
         end
         PRIME: begin
            pop         = 1'b1;
            prime_cnt_d = prime_cnt + 4'd1;
            if (prime_cnt == PRIME_LAST) begin
               state_d  = IDLE;
               primed_d = 1'b1;
            end
         end
         RUN: begin
            if (slot == LAST_SLOT) begin
               if (fifo_level >= START_LVL) begin
                  start = 1'b1;
               end else begin
                  state_d = IDLE;
                  slot_d  = '0;
               end
            end else if (slot == BUB_PREV) begin
               en_d   = 1'b1;
               fd_d   = 1'b1;
               slot_d = LAST_SLOT;
            end else begin
               take   = 1'b1;
               slot_d = slot + 6'd1;
            end
         end
         default: state_d = IDLE;
      endcase
      if (start) begin
         state_d = RUN;
         slot_d  = '0;
         take    = 1'b1;
      end
      if (take) begin
         pop      = 1'b1;
         en_d     = 1'b1;
         xn_re_d  = dl_re[LAG-1];
         xn_im_d  = dl_im[LAG-1];
         xn4_re_d = head_re;
         xn4_im_d = head_im_x;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         primed     <= 1'b0;
         prime_cnt  <= '0;
         slot       <= '0;
         en         <= 1'b0;
         frame_done <= 1'b0;
         xn_re      <= '0;
         xn_im      <= '0;
         xn4_re     <= '0;
         xn4_im     <= '0;
      end else begin
         state_q    <= state_d;
         primed     <= primed_d;
         prime_cnt  <= prime_cnt_d;
         slot       <= slot_d;
         en         <= en_d;
         frame_done <= fd_d;
         xn_re      <= xn_re_d;
         xn_im      <= xn_im_d;
         xn4_re     <= xn4_re_d;
         xn4_im     <= xn4_im_d;
      end
   end

endmodule

// File: tb/tb_corr_feeder.sv
// tb_corr_feeder: scoreboard bench for corr_feeder; queues expected xn/xn4 pairs at acceptance
// and a negedge monitor checks every presented slot. Honors CORR_FEEDER_CONJ_EN for xn4_im.

module tb_corr_feeder;

   localparam int DW      = 16;
   localparam int FRAME   = 64;
   localparam int LAG     = 4;
   localparam int FIFO_AW = 7;

   logic             clk = 1'b0;
   logic             rst;
   logic             s_valid;
   logic             s_ready;
   logic [DW-1:0]    s_re, s_im;
   logic             en;
   logic [DW-1:0]    xn_re, xn_im, xn4_re, xn4_im;
   logic             frame_done;
   logic [5:0]       slot;
   logic [FIFO_AW:0] fifo_level;

   always #5 clk = ~clk;

   corr_feeder #(.DW(DW), .FRAME(FRAME), .LAG(LAG), .FIFO_AW(FIFO_AW)) dut (
      .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready),
      .s_re(s_re), .s_im(s_im), .en(en),
      .xn_re(xn_re), .xn_im(xn_im), .xn4_re(xn4_re), .xn4_im(xn4_im),
      .frame_done(frame_done), .slot(slot), .fifo_level(fifo_level)
   );

   int checks  = 0;
   int errors  = 0;
   int acc_cnt = 0;
   int b2b     = 0;
   int exp_slot = 0;
   bit prev_en = 1'b0;
   logic [DW-1:0] q_xn_re[$], q_xn_im[$], q_x4_re[$], q_x4_im[$];
   logic [DW-1:0] e_re, e_im, e4_re, e4_im;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [DW-1:0] exp_x4_im(input logic [DW-1:0] v);
`ifdef CORR_FEEDER_CONJ_EN
      if (v == 16'h8000) return 16'h7fff;
      return 16'h0000 - v;
`else
      return v;
`endif
   endfunction

   function automatic logic [DW-1:0] im_pat(input int k);
      case (k % 4)
         0:       return 16'h0005;
         1:       return 16'h8000;
         2:       return 16'hfff9;
         default: return 16'(k);
      endcase
   endfunction

   task automatic drive(input bit v, input logic [DW-1:0] re, input logic [DW-1:0] im, output bit acc);
      @(negedge clk);
      s_valid = v;
      s_re    = re;
      s_im    = im;
      acc     = v && s_ready;
      if (acc) begin
         q_xn_re.push_back(re);
         q_xn_im.push_back(im);
         if (acc_cnt >= LAG) begin
            q_x4_re.push_back(re);
            q_x4_im.push_back(exp_x4_im(im));
         end
         acc_cnt++;
      end
   endtask

   task automatic idle_cycle();
      bit a;
      drive(1'b0, '0, '0, a);
   endtask

   task automatic wait_fd(input int budget);
      int n = 0;
      while (!frame_done && n < budget) begin
         idle_cycle();
         n++;
      end
      chk("frame_done_seen", frame_done, 1);
   endtask

   task automatic wait_en_low(input int budget);
      int n = 0;
      while (en && n < budget) begin
         idle_cycle();
         n++;
      end
      chk("en_low_after_drain", en, 0);
   endtask

   task automatic cold_start();
      bit a;
      for (int k = 0; k < 67; k++) begin
         drive(1'b1, 16'(k), '0, a);
         if (k == 12) chk("prime_pops_level", fifo_level, 8);
      end
      idle_cycle();
      chk("cold_en_before_run", en, 0);
      idle_cycle();
      chk("cold_en_run_start", en, 1);
      chk("cold_slot0_xn4", xn4_re, 4);
      wait_fd(100);
      idle_cycle();
      chk("cold_en_after_frame", en, 0);
      chk("cold_level_after_frame", fifo_level, 0);
   endtask

   // Scoreboard monitor
   always @(negedge clk) begin
      if (rst) begin
         prev_en  = 1'b0;
         exp_slot = 0;
      end else begin
         if (en) begin
            if (!prev_en) exp_slot = 0;
            else if (exp_slot == 0) b2b++;
            chk("slot", slot, exp_slot);
            if (exp_slot == FRAME-1) begin
               chk("bubble_frame_done", frame_done, 1);
               chk("bubble_x_zero", xn_re | xn_im | xn4_re | xn4_im, 0);
            end else begin
               chk("frame_done_low", frame_done, 0);
               if (q_xn_re.size() == 0 || q_x4_re.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL scoreboard_underrun: got output xn4_re=0x%0h expected no output", xn4_re);
               end else begin
                  e_re  = q_xn_re.pop_front();
                  e_im  = q_xn_im.pop_front();
                  e4_re = q_x4_re.pop_front();
                  e4_im = q_x4_im.pop_front();
                  chk("xn_re", xn_re, e_re);
                  chk("xn_im", xn_im, e_im);
                  chk("xn4_re", xn4_re, e4_re);
                  chk("xn4_im", xn4_im, e4_im);
               end
            end
            exp_slot = (exp_slot + 1) % FRAME;
         end else if (prev_en) begin
            chk("en_drop_slot", exp_slot, 0);
         end
         prev_en = en;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      bit a, full_seen, found;
      int k, n, b0, en_gaps;
      rst = 1'b1;
      s_valid = 1'b0;
      s_re = '0;
      s_im = '0;
      repeat (3) @(negedge clk);
      chk("rst_en", en, 0);
      chk("rst_frame_done", frame_done, 0);
      chk("rst_slot", slot, 0);
      chk("rst_level", fifo_level, 0);
      chk("rst_x_zero", xn_re | xn_im | xn4_re | xn4_im, 0);
      rst = 1'b0;
      #1 chk("s_ready_after_rst", s_ready, 1);

      cold_start();

      // primed, empty FIFO: 62 samples must not start a frame, the 63rd does
      for (int i = 0; i < 62; i++) drive(1'b1, 16'(100 + i), im_pat(i), a);
      repeat (5) idle_cycle();
      chk("hold_en_low", en, 0);
      chk("hold_level", fifo_level, 62);
      drive(1'b1, 16'(162), im_pat(62), a);
      idle_cycle();
      chk("hold_en_edge_e", en, 0);
      chk("hold_level_63", fifo_level, 63);
      idle_cycle();
      chk("hold_en_edge_e1", en, 1);
      wait_fd(100);
      idle_cycle();
      chk("hold_en_after", en, 0);
      chk("hold_level_after", fifo_level, 0);

      // back-to-back frames from a continuous ramp
      b0 = b2b;
      for (int i = 0; i < 255; i++) drive(1'b1, 16'(1000 + i), 16'(i), a);
      wait_en_low(400);
      chk("b2b_frames", b2b - b0, 3);
      chk("b2b_leftover", fifo_level, 3);

      // backpressure: hold valid until the FIFO fills, then keep pushing
      k = 0;
      n = 0;
      full_seen = 1'b0;
      while (!full_seen && n < 6000) begin
         drive(1'b1, 16'(k), ~16'(k), a);
         if (a) k++;
         else begin
            full_seen = 1'b1;
            chk("full_level", fifo_level, 128);
         end
         n++;
      end
      chk("full_seen", full_seen, 1);
      en_gaps = 0;
      for (int i = 0; i < 300; i++) begin
         drive(1'b1, 16'(k), ~16'(k), a);
         if (a) k++;
         if (!en) en_gaps++;
      end
      chk("bp_en_gaps", en_gaps, 0);
      wait_en_low(400);

      // reset mid-frame at slot 30
      n = 0;
      found = 1'b0;
      while (!found && n < 300) begin
         drive(1'b1, 16'(5000 + n), '0, a);
         n++;
         if (en && slot == 6'd30) found = 1'b1;
      end
      chk("slot30_reached", found, 1);
      rst = 1'b1;
      s_valid = 1'b0;
      #1;
      chk("midrst_en", en, 0);
      chk("midrst_x_zero", xn_re | xn_im | xn4_re | xn4_im, 0);
      chk("midrst_level", fifo_level, 0);
      chk("midrst_slot", slot, 0);
      q_xn_re.delete();
      q_xn_im.delete();
      q_x4_re.delete();
      q_x4_im.delete();
      acc_cnt = 0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      cold_start();
      repeat (3) idle_cycle();
      chk("x4_queue_drained", q_x4_re.size(), 0);
      chk("xn_queue_in_delay_line", q_xn_re.size(), LAG);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
